spi_controller: RTL and testbench

SPI mode-0 initiator that drives the on-chip SPI register peripheral (and any compatible device) from a simple valid/ready request interface. Each request produces one 16-bit frame under a single nCS low period: {rw, addr[6:0], data[7:0]}, MSB first. Write frames load the target register; read frames shift out the address and capture 8 bits from CIPO. Used in the test harness and in system-level loopback against the peripheral.

---
 rtl/spi_pkg.sv | 44 ++++
 rtl/spi_sclk_gen.sv | 58 +++++
 rtl/spi_controller.sv | 178 +++++++++++++++++
 tb/tb_spi_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_pkg                                                |
// | Description : Shared frame geometry, register map and FSM states for |
// |               the SPI initiator and its sub-blocks.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package spi_pkg;

   localparam int SPI_FRAME_W = 16;
   localparam int SPI_ADDR_W  = 7;
   localparam int SPI_DATA_W  = 8;

   // Position of the read/write flag in the frame and its encodings
   localparam int   SPI_RW_BIT = 15;
   localparam logic SPI_WRITE  = 1'b1;
   localparam logic SPI_READ   = 1'b0;

   // Peripheral register map
   localparam logic [SPI_ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
   localparam logic [SPI_ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
   localparam logic [SPI_ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
   localparam logic [SPI_ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
   localparam logic [SPI_ADDR_W-1:0] PWM_DUTY    = 7'h04;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

   // Largest of three phase lengths, used to size the shared phase counter
   function automatic int spi_max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_sclk_gen                                           |
// | Description : SCLK divider. Produces the idle-low SCLK level and     |
// |               one-cycle strobes on the cycle before each edge.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic sclk,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;

   // Count out each half-period; toggle SCLK at wrap, park low when disabled
   always_comb begin
      div_d     = '0;
      sclk_d    = 1'b0;
      rise_tick = 1'b0;
      fall_tick = 1'b0;
      if (en) begin
         if (div_q == DIV_LAST) begin
            div_d     = '0;
            sclk_d    = ~sclk_q;
            rise_tick = ~sclk_q;
            fall_tick = sclk_q;
         end else begin
            div_d  = div_q + 1'b1;
            sclk_d = sclk_q;
         end
      end
   end

   // Divider and SCLK level registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_controller                                         |
// | Description : SPI mode-0 initiator. One request becomes one 16-bit   |
// |               {rw, addr, data} frame under a single nCS low period.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [SPI_ADDR_W-1:0] req_addr,
   input  logic [SPI_DATA_W-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [SPI_DATA_W-1:0] rsp_rdata,
   output logic                  busy,
   output logic                  sclk,
   output logic                  copi,
   output logic                  ncs,
   input  logic                  cipo
);

   localparam int CNT_MAX = spi_max3(CS_SETUP, CS_HOLD, CS_GAP);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);

   spi_state_e                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [3:0]                 bit_q, bit_d;
   logic [SPI_FRAME_W-1:0]     shift_q, shift_d;
   logic                       is_write_q, is_write_d;
   logic                       cap_arm_q, cap_arm_d;
   logic [SPI_DATA_W-1:0]      rx_q, rx_d;
   logic [SPI_DATA_W-1:0]      rdata_q, rdata_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic                       ncs_q, ncs_d;
   logic                       cipo_meta_q, cipo_sync_q;
   logic                       sclk_en, sclk_rise, sclk_fall;

   assign sclk_en = (state_q == ST_SHIFT);

   spi_sclk_gen #(
      .CLK_DIV   (CLK_DIV)
   ) u_sclk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (sclk_en),
      .sclk      (sclk),
      .rise_tick (sclk_rise),
      .fall_tick (sclk_fall)
   );

   // Two-flop synchronizer for the asynchronous peripheral data line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cipo_meta_q <= 1'b0;
         cipo_sync_q <= 1'b0;
      end else begin
         cipo_meta_q <= cipo;
         cipo_sync_q <= cipo_meta_q;
      end
   end

   // Frame sequencing: next state, shift/capture and response generation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      is_write_d  = is_write_q;
      cap_arm_d   = cap_arm_q;
      rx_d        = rx_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      ncs_d       = ncs_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               state_d    = ST_SETUP;
               cnt_d      = SETUP_LD;
               bit_d      = 4'd15;
               shift_d    = {req_write, req_addr, req_wdata};
               is_write_d = req_write;
               cap_arm_d  = 1'b0;
               rx_d       = '0;
               ncs_d      = 1'b0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) state_d = ST_SHIFT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_SHIFT: begin
            // Arm capture on the rising edge of the data-byte bits only
            if (sclk_rise) cap_arm_d = (bit_q < 4'd8);
            // Last high cycle: capture CIPO, then advance COPI as SCLK falls
            if (sclk_fall) begin
               if (cap_arm_q) rx_d = {rx_q[SPI_DATA_W-2:0], cipo_sync_q};
               if (bit_q == 4'd0) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LD;
               end else begin
                  bit_d   = bit_q - 1'b1;
                  shift_d = {shift_q[SPI_FRAME_W-2:0], 1'b0};
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d     = ST_GAP;
               cnt_d       = GAP_LD;
               ncs_d       = 1'b1;
               shift_d     = '0;
               rsp_valid_d = 1'b1;
               if (!is_write_q) rdata_d = rx_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            ncs_d   = 1'b1;
            shift_d = '0;
         end
      endcase
   end

   // State and datapath registers; reset forces the bus idle immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_q       <= 4'd0;
         shift_q     <= '0;
         is_write_q  <= 1'b0;
         cap_arm_q   <= 1'b0;
         rx_q        <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         ncs_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         is_write_q  <= is_write_d;
         cap_arm_q   <= cap_arm_d;
         rx_q        <= rx_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         ncs_q       <= ncs_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign copi      = shift_q[SPI_RW_BIT];
   assign ncs       = ncs_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_spi_controller                                      |
// | Description : Self-checking bench for spi_controller: default and    |
// |               slow-SCLK instances against a frame-level model.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_spi_controller;
   import spi_pkg::*;

   typedef struct packed {
      logic [15:0] frame;
      logic        rd;
      logic [7:0]  rbyte;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_write = 1'b0;
   logic [6:0] req_addr = 7'h00;
   logic [7:0] req_wdata = 8'h00;
   logic [7:0] rd_byte = 8'h00;
   logic       req_valid_a [2];
   logic       req_ready_a [2];
   logic       busy_a      [2];
   logic       rsp_valid_a [2];
   logic [7:0] rsp_rdata_a [2];
   logic       sclk_a      [2];
   logic       copi_a      [2];
   logic       ncs_a       [2];
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Instance 0 uses defaults; instance 1 uses CLK_DIV=8, CS_SETUP=1, CS_HOLD=1
   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int DIV     = (g == 0) ? 4 : 8;
      localparam int SET     = (g == 0) ? 2 : 1;
      localparam int HLD     = (g == 0) ? 2 : 1;
      localparam int GAP     = 4;
      localparam int LOW_LEN = SET + 32 * DIV + HLD;

      logic        cipo;
      exp_t        q[$];
      int          left;
      int          low_len, high_len, since_edge, rises, falls, last_len, n_frames;
      logic [15:0] word, last_frame;
      logic [7:0]  exp_rdata;
      logic        prev_ncs, prev_sclk, prev_copi, had_frame;

      spi_controller #(
         .CLK_DIV   (DIV),
         .CS_SETUP  (SET),
         .CS_HOLD   (HLD),
         .CS_GAP    (GAP)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (req_valid_a[g]),
         .req_ready (req_ready_a[g]),
         .req_write (req_write),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .rsp_valid (rsp_valid_a[g]),
         .rsp_rdata (rsp_rdata_a[g]),
         .busy      (busy_a[g]),
         .sclk      (sclk_a[g]),
         .copi      (copi_a[g]),
         .ncs       (ncs_a[g]),
         .cipo      (cipo)
      );

      initial begin
         n_frames   = 0;
         last_len   = 0;
         last_frame = 16'h0000;
      end

      // Model: a request is taken whenever the controller is idle; it is then busy for the whole frame plus gap
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            left <= 0;
         end else if (left > 0) begin
            left <= left - 1;
         end else if (req_valid_a[g]) begin
            left <= LOW_LEN + GAP;
            q.push_back({req_write, req_addr, req_wdata, ~req_write, rd_byte});
         end
      end

      // Compare process plus CIPO responder, sampled on the falling clk edge
      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            exp_rdata = 8'h00;
            prev_ncs  = 1'b1;
            prev_sclk = 1'b0;
            prev_copi = 1'b0;
            had_frame = 1'b0;
            cipo      = 1'b0;
            rises     = 0;
            falls     = 0;
            high_len  = 0;
            low_len   = 0;
         end else begin
            check("busy", busy_a[g], left > 0);
            check("req_ready", req_ready_a[g], left == 0);
            if (ncs_a[g]) check("sclk_low_when_ncs_high", sclk_a[g], 1'b0);
            if (prev_ncs && !ncs_a[g]) begin
               if (had_frame) check("ncs_gap_ge_cs_gap", high_len >= GAP, 1'b1);
               low_len = 1; since_edge = 0; rises = 0; falls = 0; word = 16'h0; cipo = 1'b0;
            end else if (!ncs_a[g]) begin
               low_len++; since_edge++;
            end else begin
               high_len++;
            end
            if (!ncs_a[g]) begin
               if (!prev_sclk && sclk_a[g]) begin
                  check("sclk_rise_spacing", since_edge, (rises == 0) ? SET + DIV : 2 * DIV);
                  rises++;
                  word = {word[14:0], copi_a[g]};
                  since_edge = 0;
               end
               if (prev_sclk && sclk_a[g]) check("copi_stable_while_high", copi_a[g], prev_copi);
               if (prev_sclk && !sclk_a[g]) begin
                  falls++;
                  if (falls >= 8 && falls <= 15 && q.size() > 0 && q[0].rd)
                     cipo = q[0].rbyte[15 - falls];
               end
            end
            if (!prev_ncs && ncs_a[g]) begin
               check("ncs_low_len", low_len, LOW_LEN);
               check("sclk_rise_count", rises, 16);
               check("rsp_valid_at_ncs_rise", rsp_valid_a[g], 1'b1);
               if (q.size() == 0) begin
                  check("frame_was_requested", 1'b0, 1'b1);
               end else begin
                  check("copi_frame", word, q[0].frame);
                  if (q[0].rd) exp_rdata = q[0].rbyte;
                  void'(q.pop_front());
               end
               last_frame = word; last_len = low_len; n_frames++;
               had_frame = 1'b1; high_len = 1; cipo = 1'b0;
            end else begin
               check("rsp_valid_quiet", rsp_valid_a[g], 1'b0);
            end
            check("rsp_rdata", rsp_rdata_a[g], exp_rdata);
            prev_ncs  = ncs_a[g];
            prev_sclk = sclk_a[g];
            prev_copi = copi_a[g];
         end
      end
   end

   // Present a request and keep it valid until the controller has taken it
   task automatic send(input int g, input logic w, input logic [6:0] a, input logic [7:0] d);
      int k;
      req_write = w; req_addr = a; req_wdata = d;
      req_valid_a[g] = 1'b1;
      k = 0;
      while (!req_ready_a[g] && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) check("accept_timeout", 1'b0, 1'b1);
      @(negedge clk);
   endtask

   // Drop the request and scramble the fields so a late change would show in the frame
   task automatic drop(input int g);
      req_valid_a[g] = 1'b0;
      req_write = ~req_write; req_addr = 7'h7F; req_wdata = 8'h5A;
   endtask

   task automatic wait_idle(input int g);
      int k;
      k = 0;
      @(negedge clk);
      while (busy_a[g] && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) check("idle_timeout", 1'b0, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int k;
      req_valid_a[0] = 1'b0;
      req_valid_a[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_ncs", ncs_a[0], 1'b1);
      check("reset_sclk", sclk_a[0], 1'b0);
      check("reset_copi", copi_a[0], 1'b0);
      check("reset_ready", req_ready_a[0], 1'b1);
      check("reset_rdata", rsp_rdata_a[0], 8'h00);

      // Write addr 0x02 data 0xA5
      send(0, SPI_WRITE, EN_PWM_7_0, 8'hA5); drop(0); wait_idle(0);
      check("wr02_frame", g_inst[0].last_frame, 16'h82A5);
      check("wr02_ncs_len", g_inst[0].last_len, 132);
      check("wr02_rdata_kept", rsp_rdata_a[0], 8'h00);

      // Read addr 0x04, peripheral returns 0x3C
      rd_byte = 8'h3C;
      send(0, SPI_READ, PWM_DUTY, 8'h00); drop(0); wait_idle(0);
      check("rd04_frame", g_inst[0].last_frame, 16'h0400);
      check("rd04_rdata", rsp_rdata_a[0], 8'h3C);

      // Two queued writes with valid held high across both
      rd_byte = 8'h00;
      send(0, SPI_WRITE, EN_OUT_7_0, 8'hFF);
      send(0, SPI_WRITE, EN_OUT_15_8, 8'h0F); drop(0); wait_idle(0);
      check("queued_frames", g_inst[0].n_frames, 4);
      check("queued_last_frame", g_inst[0].last_frame, 16'h810F);
      check("queued_rdata_kept", rsp_rdata_a[0], 8'h3C);

      // Reset during the high phase of bit 7
      send(0, SPI_WRITE, EN_PWM_7_0, 8'hA5); drop(0);
      k = 0;
      while (g_inst[0].rises < 9 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) check("bit7_timeout", 1'b0, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_ncs", ncs_a[0], 1'b1);
      check("midrst_sclk", sclk_a[0], 1'b0);
      check("midrst_copi", copi_a[0], 1'b0);
      check("midrst_busy", busy_a[0], 1'b0);
      check("midrst_rsp_valid", rsp_valid_a[0], 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_frames", g_inst[0].n_frames, 4);
      check("midrst_rdata", rsp_rdata_a[0], 8'h00);
      send(0, SPI_WRITE, EN_PWM_15_8, 8'h55); drop(0); wait_idle(0);
      check("postrst_frame", g_inst[0].last_frame, 16'h8355);
      check("postrst_frames", g_inst[0].n_frames, 5);

      // Slow-SCLK instance
      send(1, SPI_WRITE, PWM_DUTY, 8'h80); drop(1); wait_idle(1);
      check("div8_frame", g_inst[1].last_frame, 16'h8480);
      check("div8_ncs_len", g_inst[1].last_len, 258);
      send(1, SPI_WRITE, EN_OUT_7_0, 8'hF0); drop(1); wait_idle(1);
      check("div8_frame2", g_inst[1].last_frame, 16'h80F0);
      check("div8_frames", g_inst[1].n_frames, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
